wall_clock_multi: RTL and testbench

- Parametrised stopwatch/countdown timer; successor to the fixed 4-digit wall clock.
- Generalised in digit count and tick rate; adds count-down mode, preset load, lap hold, terminal-count pulse and a blinking separator when paused.
- Drives BCD digits plus decimal-point enables to the board seven-segment scanner.

---
 rtl/wall_clock_multi.sv | 173 +++++++++++++++++
 tb/tb_wall_clock_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_clock_multi.sv
// wall_clock_multi: parametrised BCD stopwatch / countdown timer.
// Digit 0 is 1/100 s. Odd digits from 3 upward count modulo 6, all
// other digits count modulo 10. The design supports count-up and
// count-down, preset load, lap hold, a one-cycle terminal-count pulse,
// and a separator that blinks while the count is stopped.
// There are no valid/ready handshakes. load and lap are one-cycle
// strobes that act on the clock edge where they are sampled high.
module wall_clock_multi #(
  parameter int NDIG        = 4,
  parameter int TICK_DIV    = 500000,
  parameter int BLINK_TICKS = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stop,
  input  logic                mode,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_value,
  input  logic                lap,
  output logic [4*NDIG-1:0]   Time_out,
  output logic [NDIG-1:0]     s_point,
  output logic                done,
  output logic                lap_active
);

  localparam int W  = 4 * NDIG;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // Largest legal value of digit i.
  function automatic logic [3:0] radix_max(input int i);
    return ((i % 2 == 1) && (i >= 3)) ? 4'd5 : 4'd9;
  endfunction

  // Separator positions: every even digit from 2 upward.
  function automatic logic [NDIG-1:0] sep_mask();
    logic [NDIG-1:0] m;
    m = '0;
    for (int i = 2; i < NDIG; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  // All digits at their maximum (the wrap point when counting up).
  function automatic logic [W-1:0] max_value();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = radix_max(i);
    return v;
  endfunction

  localparam logic [NDIG-1:0] MASK = sep_mask();
  localparam logic [W-1:0]    MAXV = max_value();

  // Ripple increment. A digit at its maximum wraps to 0 and carries.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == radix_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple decrement. The caller never passes an all-zero value.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = radix_max(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Out-of-range preset digits saturate at the digit's maximum.
  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NDIG; i++)
      if (v[4*i +: 4] > radix_max(i)) r[4*i +: 4] = radix_max(i);
    return r;
  endfunction

  logic [PW-1:0] presc;
  logic          tick;
  logic [W-1:0]  count;
  logic [W-1:0]  lap_reg;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // The prescaler free-runs regardless of stop. A load restarts it.
  always_ff @(posedge clk) begin
    if (reset || load) presc <= '0;
    else if (tick)     presc <= '0;
    else               presc <= presc + PW'(1);
  end

  // Main count. Load wins over tick. done is a registered one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= clamp(load_value);
      end else if (tick && !stop) begin
        if (!mode) begin
          count <= bcd_inc(count);
          if (count == MAXV) done <= 1'b1;
        end else if (count != '0) begin
          count <= bcd_dec(count);
          if (count == W'(1)) done <= 1'b1;
        end
      end
    end
  end

  // Lap toggle. Capturing takes the pre-update count, even when a load
  // arrives on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_reg    <= '0;
      lap_active <= 1'b0;
    end else if (lap) begin
      if (!lap_active) begin
        lap_reg    <= count;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  // Blink phase. The phase is held "on" while the count runs, so each
  // stop starts with the separator lit.
  always_ff @(posedge clk) begin
    if (reset || !stop) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign Time_out = lap_active ? lap_reg : count;
  assign s_point  = (!stop || blink_on) ? MASK : '0;

endmodule

// File: tb/tb_wall_clock_multi.sv
// Testbench for wall_clock_multi with NDIG=4, TICK_DIV=2, BLINK_TICKS=2.
// The reference model holds the count as an integer number of
// centiseconds in a mixed-radix space. It converts to and from BCD only
// at the boundaries.
module tb_wall_clock_multi;

  localparam int NDIG        = 4;
  localparam int TICK_DIV    = 2;
  localparam int BLINK_TICKS = 2;
  localparam int W           = 4 * NDIG;

  // Clock and reset block.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic            stop = 1'b0;
  logic            mode = 1'b0;
  logic            load = 1'b0;
  logic [W-1:0]    load_value = '0;
  logic            lap = 1'b0;
  logic [W-1:0]    Time_out;
  logic [NDIG-1:0] s_point;
  logic            done;
  logic            lap_active;

  wall_clock_multi #(
    .NDIG(NDIG), .TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .stop(stop), .mode(mode), .load(load),
    .load_value(load_value), .lap(lap), .Time_out(Time_out),
    .s_point(s_point), .done(done), .lap_active(lap_active)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_cnt = 0, m_lap = 0, m_presc = 0, m_blink_n = 0;
  bit m_lap_act = 0, m_done = 0, m_blink_on = 1;
  logic [W-1:0] exp_q[$];

  function automatic int rdx(input int i);
    return ((i % 2 == 1) && (i >= 3)) ? 6 : 10;
  endfunction

  function automatic int modulus();
    int m;
    m = 1;
    for (int i = 0; i < NDIG; i++) m = m * rdx(i);
    return m;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int t;
    b = '0;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      b[4*i +: 4] = 4'(t % rdx(i));
      t = t / rdx(i);
    end
    return b;
  endfunction

  function automatic int from_bcd_clamp(input logic [W-1:0] b);
    int v, wgt, d;
    v = 0;
    wgt = 1;
    for (int i = 0; i < NDIG; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > rdx(i) - 1) d = rdx(i) - 1;
      v = v + d * wgt;
      wgt = wgt * rdx(i);
    end
    return v;
  endfunction

  function automatic logic [NDIG-1:0] exp_mask();
    logic [NDIG-1:0] m;
    m = '0;
    for (int i = 0; i < NDIG; i++) m[i] = (i >= 2) && (i % 2 == 0);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, using the inputs applied before it.
  task automatic model_step();
    bit tk;
    tk = (m_presc == TICK_DIV - 1);
    if (reset) begin
      m_cnt = 0; m_lap = 0; m_lap_act = 0; m_done = 0;
      m_presc = 0; m_blink_n = 0; m_blink_on = 1;
    end else begin
      if (lap) begin
        if (!m_lap_act) begin m_lap = m_cnt; m_lap_act = 1; end
        else m_lap_act = 0;
      end
      m_done = 0;
      if (load) begin
        m_cnt = from_bcd_clamp(load_value);
        m_presc = 0;
      end else begin
        m_presc = tk ? 0 : m_presc + 1;
        if (tk && !stop) begin
          if (!mode) begin
            if (m_cnt == modulus() - 1) m_done = 1;
            m_cnt = (m_cnt + 1) % modulus();
          end else if (m_cnt > 0) begin
            if (m_cnt == 1) m_done = 1;
            m_cnt = m_cnt - 1;
          end
        end
      end
      if (!stop) begin
        m_blink_on = 1; m_blink_n = 0;
      end else if (tk) begin
        m_blink_n++;
        if (m_blink_n == BLINK_TICKS) begin m_blink_n = 0; m_blink_on = !m_blink_on; end
      end
    end
    exp_q.push_back(to_bcd(m_lap_act ? m_lap : m_cnt));
  endtask

  // Scoreboard: compare every output against the model.
  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("time_out", 32'(Time_out), 32'(e));
    check("s_point", 32'(s_point), 32'((!stop || m_blink_on) ? exp_mask() : '0));
    check("done", 32'(done), 32'(m_done));
    check("lap_active", 32'(lap_active), 32'(m_lap_act));
  endtask

  // Driver: one clock, then clear the single-cycle strobes.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    load = 1'b0;
    lap  = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_value = v;
    load = 1'b1;
    cycle();
  endtask

  initial begin
    // Reset for 3 cycles, then count up.
    reset = 1'b1;
    cycles(3);
    check("reset_time", 32'(Time_out), 32'h0);
    check("reset_spoint", 32'(s_point), 32'b0100);
    check("reset_done", 32'(done), 32'h0);
    reset = 1'b0;
    cycles(2);
    check("first_tick", 32'(Time_out), 32'h0001);
    cycles(18);
    check("ten_ticks", 32'(Time_out), 32'h0010);
    cycles(180);
    check("hundred_ticks", 32'(Time_out), 32'h0100);

    // Wrap at the maximum value.
    do_load(16'h5998);
    cycles(2);
    check("pre_wrap", 32'(Time_out), 32'h5999);
    cycles(2);
    check("wrap_zero", 32'(Time_out), 32'h0000);
    check("wrap_done", 32'(done), 32'h1);
    cycle();
    check("wrap_done_clr", 32'(done), 32'h0);

    // Count down to zero, then hold.
    mode = 1'b1;
    do_load(16'h0003);
    cycles(2);
    check("down_2", 32'(Time_out), 32'h0002);
    cycles(2);
    check("down_1", 32'(Time_out), 32'h0001);
    cycles(2);
    check("down_0", 32'(Time_out), 32'h0000);
    check("down_done", 32'(done), 32'h1);
    cycles(20);
    check("down_hold", 32'(Time_out), 32'h0000);

    // Clamped load that coincides with a tick.
    mode = 1'b0;
    cycle();
    do_load(16'h7AFF);
    check("clamp_load", 32'(Time_out), 32'h5999);
    cycle();
    check("presc_restart", 32'(Time_out), 32'h5999);
    cycle();
    check("clamp_wrap", 32'(Time_out), 32'h0000);

    // Lap hold while the count continues.
    do_load(16'h0000);
    cycles(10);
    lap = 1'b1;
    cycle();
    check("lap_hold", 32'(Time_out), 32'h0005);
    check("lap_on", 32'(lap_active), 32'h1);
    cycles(39);
    check("lap_still", 32'(Time_out), 32'h0005);
    lap = 1'b1;
    cycle();
    check("lap_release", 32'(Time_out), 32'h0025);
    lap = 1'b1;
    do_load(16'h0100);
    check("lap_preload", 32'(Time_out), 32'h0025);
    lap = 1'b1;
    cycle();
    check("lap_postload", 32'(Time_out), 32'h0100);

    // Stop and blink.
    do_load(16'h1234);
    stop = 1'b1;
    cycles(4);
    check("blink_off", 32'(s_point), 32'b0000);
    cycles(4);
    check("blink_on", 32'(s_point), 32'b0100);
    check("stop_frozen", 32'(Time_out), 32'h1234);
    stop = 1'b0;
    cycle();
    check("run_spoint", 32'(s_point), 32'b0100);
    stop = 1'b1;
    lap = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycle();
    check("rst_blink_sp", 32'(s_point), 32'b0100);
    check("rst_blink_time", 32'(Time_out), 32'h0000);
    check("rst_lap", 32'(lap_active), 32'h0);
    reset = 1'b0;
    stop = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      stop  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 29) == 0);
      load_value = W'($urandom);
      lap   = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 149) == 0);
      cycle();
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
